// File: rtl/life_scan_reader.sv
`default_nettype none
// ============================================================================
//  Module      : life_scan_reader
//  Description : Scan-chain readout controller for life_array_4x4. On request
//                it pauses the array, rotates all CELLS states once around the
//                scan chain (feeding every bit back in so the board is left
//                intact) and presents the captured board on a valid/ready
//                handshake, together with extinct / still-life flags.
//
//  Ports       : clk            - single clock, rising edge
//                reset          - asynchronous, active-low reset
//                req            - snapshot request, honoured only in IDLE
//                run_in         - run request from the controlling logic
//                run_out        - drives array run (forced low while busy)
//                scan           - drives array scan
//                scan_write_enb - drives array scan_write_enb
//                scan_write_val - drives array scan_write_val (recirculated)
//                scan_read_val  - tail of the array scan chain
//                busy           - high in any state other than IDLE
//                snap_valid     - snapshot available
//                snap_ready     - consumer accepts the snapshot
//                snapshot       - board state, bit i = row i/4, col i%4
//                extinct        - snapshot is all zero (valid-qualified)
//                stable         - snapshot equals previously accepted one
//
//  Revision    : 1.0 - initial release
// ============================================================================
module life_scan_reader #(
    parameter int CELLS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             run_in,
    output logic             run_out,
    output logic             scan,
    output logic             scan_write_enb,
    output logic             scan_write_val,
    input  logic             scan_read_val,
    output logic             busy,
    output logic             snap_valid,
    input  logic             snap_ready,
    output logic [CELLS-1:0] snapshot,
    output logic             extinct,
    output logic             stable
);

    localparam int c_cnt_w = (CELLS > 1) ? $clog2(CELLS) : 1;

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CELLS - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_pause = 2'd1;
    localparam logic [1:0] c_st_shift = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [CELLS-1:0]   r_shreg;
    logic [CELLS-1:0]   r_prev;
    logic               r_have_prev;
    logic               w_in_shift;
    logic               w_accept;

    assign w_in_shift = (r_state == c_st_shift);
    assign w_accept   = snap_valid && snap_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (req)                 w_state_nxt = c_st_pause;
            // One dead cycle so the array cannot take a generation step on
            // the same edge the first scan shift happens.
            c_st_pause:                          w_state_nxt = c_st_shift;
            c_st_shift: if (r_cnt == c_cnt_last) w_state_nxt = c_st_done;
            c_st_done:  if (w_accept)            w_state_nxt = c_st_idle;
            default:                             w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_shreg     <= '0;
            r_prev      <= '0;
            r_have_prev <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_in_shift) begin
                // First bit read is the chain tail (cell CELLS-1); after
                // CELLS shifts it has walked up to the MSB, so the register
                // ends up bit-aligned with the array.
                r_shreg <= {r_shreg[CELLS-2:0], scan_read_val};
                r_cnt   <= (r_cnt == c_cnt_last) ? '0 : (r_cnt + c_cnt_one);
            end

            if (w_accept) begin
                r_prev      <= r_shreg;
                r_have_prev <= 1'b1;
            end
        end
    end

    // The array may only advance while the reader is idle; once a snapshot
    // is pending the board is frozen until the consumer takes it.
    assign run_out        = (r_state == c_st_idle) ? run_in : 1'b0;
    assign scan           = w_in_shift;
    assign scan_write_enb = w_in_shift;
    // Recirculate the tail back into the head so the board is preserved.
    assign scan_write_val = w_in_shift & scan_read_val;

    assign busy       = (r_state != c_st_idle);
    assign snap_valid = (r_state == c_st_done);
    assign snapshot   = r_shreg;
    assign extinct    = snap_valid && (r_shreg == '0);
    assign stable     = snap_valid && r_have_prev && (r_shreg == r_prev);

endmodule
`default_nettype wire

// File: tb/tb_life_scan_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_life_scan_reader
//  Description : Directed self-checking bench for life_scan_reader, driving
//                it against a behavioural 4x4 Game of Life array (dead
//                border, B3/S23) with a recirculating scan chain.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_life_scan_reader;

    localparam int CELLS = 16;

    logic             clk;
    logic             reset;
    logic             req;
    logic             run_in;
    logic             run_out;
    logic             scan;
    logic             scan_write_enb;
    logic             scan_write_val;
    logic             scan_read_val;
    logic             busy;
    logic             snap_valid;
    logic             snap_ready;
    logic [CELLS-1:0] snapshot;
    logic             extinct;
    logic             stable;

    int n_tests;
    int n_fail;
    int n_accept;

    // Behavioural array
    logic [15:0] alive;
    logic        arr_load;
    logic [15:0] arr_load_val;

    life_scan_reader #(.CELLS(CELLS)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .run_in         (run_in),
        .run_out        (run_out),
        .scan           (scan),
        .scan_write_enb (scan_write_enb),
        .scan_write_val (scan_write_val),
        .scan_read_val  (scan_read_val),
        .busy           (busy),
        .snap_valid     (snap_valid),
        .snap_ready     (snap_ready),
        .snapshot       (snapshot),
        .extinct        (extinct),
        .stable         (stable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] life_next(input logic [15:0] a);
        logic [15:0] n;
        int          nb;
        n = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                nb = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (!(dr == 0 && dc == 0) && (r + dr) >= 0 && (r + dr) < 4 &&
                            (c + dc) >= 0 && (c + dc) < 4)
                            nb += int'(a[(r + dr) * 4 + (c + dc)]);
                    end
                end
                n[r * 4 + c] = (nb == 3) || (a[r * 4 + c] && nb == 2);
            end
        end
        return n;
    endfunction

    assign scan_read_val = alive[15];

    always @(posedge clk) begin
        if (arr_load)
            alive <= arr_load_val;
        else if (scan && scan_write_enb)
            alive <= {alive[14:0], scan_write_val};
        else if (run_out)
            alive <= life_next(alive);
    end

    always @(posedge clk) begin
        if (snap_valid && snap_ready)
            n_accept <= n_accept + 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [15:0] v);
        arr_load     = 1'b1;
        arr_load_val = v;
        tick();
        arr_load     = 1'b0;
    endtask

    // Pulses req for one edge and waits (bounded) for snap_valid; lat counts
    // edges after the req sampling edge.
    task automatic snap(output int lat);
        req = 1'b1;
        tick();
        req = 1'b0;
        lat = 0;
        while (!snap_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    int lat;
    int acc0;
    bit bad;

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        n_accept     = 0;
        reset        = 1'b0;
        req          = 1'b0;
        run_in       = 1'b0;
        snap_ready   = 1'b0;
        arr_load     = 1'b0;
        arr_load_val = '0;

        // ---------------- reset values ----------------
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(snap_valid), 32'd0);
        check("rst_scan", 32'(scan), 32'd0);
        check("rst_swe", 32'(scan_write_enb), 32'd0);
        check("rst_swv", 32'(scan_write_val), 32'd0);
        check("rst_snapshot", 32'(snapshot), 32'd0);
        check("rst_extinct", 32'(extinct), 32'd0);
        check("rst_stable", 32'(stable), 32'd0);
        run_in = 1'b1;
        #1;
        check("rst_run_follow1", 32'(run_out), 32'd1);
        run_in = 1'b0;
        #1;
        check("rst_run_follow0", 32'(run_out), 32'd0);

        load(16'h0660);
        reset = 1'b1;
        tick();

        // ---------------- block, run_in=0 ----------------
        snap_ready = 1'b1;
        snap(lat);
        check("block_latency", 32'(lat), 32'd17);
        check("block_snapshot", 32'(snapshot), 32'h0660);
        check("block_extinct", 32'(extinct), 32'd0);
        check("block_stable", 32'(stable), 32'd0);
        tick();
        check("block_idle", 32'(busy), 32'd0);
        check("block_alive_kept", 32'(alive), 32'h0660);

        // ---------------- still life ----------------
        run_in = 1'b1;
        repeat (3) tick();
        snap(lat);
        check("still_snapshot", 32'(snapshot), 32'h0660);
        check("still_stable", 32'(stable), 32'd1);
        check("still_run_gated", 32'(run_out), 32'd0);
        tick();
        run_in = 1'b0;

        // ---------------- beacon oscillator ----------------
        load(16'hCC33);
        snap(lat);
        check("beacon0_snapshot", 32'(snapshot), 32'hCC33);
        check("beacon0_stable", 32'(stable), 32'd0);
        tick();
        run_in = 1'b1;
        tick();
        run_in = 1'b0;
        snap(lat);
        check("beacon1_snapshot", 32'(snapshot), 32'hC813);
        check("beacon1_stable", 32'(stable), 32'd0);
        tick();
        run_in = 1'b1;
        tick();
        run_in = 1'b0;
        snap(lat);
        check("beacon2_snapshot", 32'(snapshot), 32'hCC33);
        check("beacon2_stable", 32'(stable), 32'd0);
        tick();

        // ---------------- extinct ----------------
        load(16'h0001);
        run_in = 1'b1;
        repeat (3) tick();
        snap(lat);
        check("extinct_snapshot", 32'(snapshot), 32'h0000);
        check("extinct_flag", 32'(extinct), 32'd1);
        check("extinct_stable", 32'(stable), 32'd0);
        tick();
        run_in = 1'b0;

        // ---------------- toad run gating + back-pressure ----------------
        snap_ready = 1'b0;
        load(16'h6186);
        req = 1'b1;
        tick();
        req    = 1'b0;
        run_in = 1'b1;
        check("toad_pause_alive", 32'(alive), 32'h6186);
        check("toad_pause_scan", 32'(scan), 32'd0);
        bad = 1'b0;
        lat = 0;
        while (!snap_valid && lat < 40) begin
            if (run_out !== 1'b0) bad = 1'b1;
            tick();
            lat++;
        end
        check("toad_latency", 32'(lat), 32'd17);
        check("toad_snapshot", 32'(snapshot), 32'h6186);
        check("toad_stable", 32'(stable), 32'd0);
        acc0 = n_accept;
        for (int i = 0; i < 20; i++) begin
            if (snapshot !== 16'h6186 || run_out !== 1'b0 || alive !== 16'h6186 ||
                snap_valid !== 1'b1)
                bad = 1'b1;
            req = (i == 5);
            tick();
        end
        req = 1'b0;
        check("toad_gated_hold", 32'(bad), 32'd0);
        snap_ready = 1'b1;
        tick();
        snap_ready = 1'b0;
        check("bp_idle_busy", 32'(busy), 32'd0);
        check("bp_idle_valid", 32'(snap_valid), 32'd0);
        check("bp_run_restored", 32'(run_out), 32'd1);
        repeat (3) tick();
        check("bp_req_not_queued", 32'(busy), 32'd0);
        check("bp_one_accept", 32'(n_accept - acc0), 32'd1);
        run_in = 1'b0;
        tick();

        // ---------------- reset mid-scan ----------------
        load(16'hA5C3);
        snap_ready = 1'b1;
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (8) tick();
        check("midscan_in_shift", 32'(scan), 32'd1);
        reset = 1'b0;
        #1;
        check("midscan_busy", 32'(busy), 32'd0);
        check("midscan_valid", 32'(snap_valid), 32'd0);
        check("midscan_scan", 32'(scan), 32'd0);
        check("midscan_swe", 32'(scan_write_enb), 32'd0);
        check("midscan_snapshot", 32'(snapshot), 32'd0);
        tick();
        load(16'hA5C3);
        reset = 1'b1;
        tick();
        snap(lat);
        check("rescan_latency", 32'(lat), 32'd17);
        check("rescan_snapshot", 32'(snapshot), 32'hA5C3);
        tick();

        // ---------------- reset mid-DONE clears history ----------------
        snap_ready = 1'b0;
        snap(lat);
        check("repeat_stable", 32'(stable), 32'd1);
        reset = 1'b0;
        #1;
        check("middone_valid", 32'(snap_valid), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        snap_ready = 1'b1;
        snap(lat);
        check("after_rst_snapshot", 32'(snapshot), 32'hA5C3);
        check("after_rst_stable", 32'(stable), 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
